writeback_arbiter: RTL and testbench

Writeback stage that owns the register file's single write port. It merges single-cycle results from the MEM/WB pipeline with results from long-latency units (mul/div) and buffers the long-latency results in a small FIFO. It also keeps a per-register busy scoreboard for hazard detection. Its registered outputs drive the register file's `reg_write` / `write_reg` / `write_data` inputs directly.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_result_fifo.sv | 58 +++++
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_writeback_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its result FIFO.
package wb_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot register mask; x0 maps to an all-zero mask so it can never be marked busy.
  function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [XLEN-1:0] mask;
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
// The head entry is visible combinationally so it can be written in the pop cycle.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  wb_entry_t          mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               push_en;
  logic               pop_en;

  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Payload storage carries no reset; occupancy alone decides validity.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_en && !pop_en)      count_reg <= count_reg + 1'b1;
      else if (pop_en && !push_en) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register file write port: merges MEM/WB and buffered long-latency results,
// bounds FIFO starvation and keeps the busy scoreboard. WB_FORWARD_EN adds bypass outputs.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  ll_issue,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic [XLEN-1:0]       busy
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  wb_entry_t                 head;
  wb_entry_t                 push_entry;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      pipe_take;

  logic [STARVE_CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic                      reg_write_reg, reg_write_next;
  logic [REG_ADDR_W-1:0]     write_reg_reg, write_reg_next;
  logic [XLEN-1:0]           write_data_reg, write_data_next;
  logic [XLEN-1:0]           busy_reg, busy_next;

  // Ready depends on occupancy only, so a same-cycle pop never frees room for a push.
  assign ll_ready   = !fifo_full;
  assign pipe_stall = (starve_cnt_reg == STARVE_CNT_W'(STARVE_LIMIT));
  assign fifo_push  = ll_valid && !fifo_full && (ll_rd != '0);
  assign push_entry = '{rd: ll_rd, data: ll_data};

  wb_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    fifo_pop        = 1'b0;
    pipe_take       = 1'b0;
    write_reg_next  = write_reg_reg;
    write_data_next = write_data_reg;
    starve_cnt_next = starve_cnt_reg;
    busy_next       = busy_reg;

    if (pipe_stall && !fifo_empty) begin
      fifo_pop = 1'b1;
    end else if (pipe_valid && (pipe_rd != '0)) begin
      pipe_take = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
    end

    reg_write_next = fifo_pop || pipe_take;
    if (fifo_pop) begin
      write_reg_next  = head.rd;
      write_data_next = head.data;
    end else if (pipe_take) begin
      write_reg_next  = pipe_rd;
      write_data_next = pipe_data;
    end

    if (fifo_empty || fifo_pop) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != '1) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    // Clear before set so a same-cycle issue to the popped register keeps the bit.
    if (fifo_pop) busy_next = busy_next & ~reg_onehot(head.rd);
    if (ll_issue) busy_next = busy_next | reg_onehot(ll_issue_rd);
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_reg <= '0;
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
      busy_reg       <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      reg_write_reg  <= reg_write_next;
      write_reg_reg  <= write_reg_next;
      write_data_reg <= write_data_next;
      busy_reg       <= busy_next;
    end
  end

  assign reg_write  = reg_write_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;
  assign busy       = busy_reg;

`ifdef WB_FORWARD_EN
  // Gated by reset_n so the bypass is quiet for the whole reset cycle.
  assign fwd_valid = reg_write_reg && reset_n;
  assign fwd_reg   = write_reg_reg;
  assign fwd_data  = write_data_reg;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .pipe_stall  (pipe_stall),
    .ll_issue    (ll_issue),
    .ll_issue_rd (ll_issue_rd),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .busy        (busy)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  // Reference state: buffered results, busy set, head wait time, expected write port.
  res_t        q[$];
  logic [31:0] m_busy  = '0;
  int          m_wait  = 0;
  logic        m_rw    = 1'b0;
  logic [4:0]  m_wreg  = '0;
  logic [31:0] m_wdata = '0;
  bit          m_init  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int   size_before;
    bit   popped;
    res_t e;
    size_before = q.size();
    popped      = 1'b0;
    if (!reset_n) begin
      q.delete();
      m_busy  = '0;
      m_wait  = 0;
      m_rw    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
      return;
    end
    m_rw = 1'b0;
    if (m_wait == LIMIT && size_before > 0) begin
      popped = 1'b1;
    end else if (pipe_valid && pipe_rd != 0) begin
      m_rw    = 1'b1;
      m_wreg  = pipe_rd;
      m_wdata = pipe_data;
    end else if (size_before > 0) begin
      popped = 1'b1;
    end
    if (popped) begin
      e       = q.pop_front();
      m_rw    = 1'b1;
      m_wreg  = e.rd;
      m_wdata = e.data;
      m_busy[e.rd] = 1'b0;
    end
    if (ll_issue && ll_issue_rd != 0) m_busy[ll_issue_rd] = 1'b1;
    if (ll_valid && size_before < DEPTH && ll_rd != 0) begin
      e.rd   = ll_rd;
      e.data = ll_data;
      q.push_back(e);
    end
    m_wait = (size_before == 0 || popped) ? 0 : m_wait + 1;
  endtask

  // Inputs are already driven (at a negedge); advance one clock and compare everything.
  task automatic step();
    if (m_init) begin
      check_value("ll_ready", ll_ready, (q.size() < DEPTH) ? 1 : 0);
      check_value("pipe_stall", pipe_stall, (m_wait == LIMIT) ? 1 : 0);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    m_init = 1'b1;
    check_value("reg_write", reg_write, m_rw);
    check_value("write_reg", write_reg, m_wreg);
    check_value("write_data", write_data, m_wdata);
    check_value("busy", busy, m_busy);
  endtask

  task automatic idle();
    reset_n     = 1'b1;
    pipe_valid  = 1'b0;
    pipe_rd     = '0;
    pipe_data   = '0;
    ll_issue    = 1'b0;
    ll_issue_rd = '0;
    ll_valid    = 1'b0;
    ll_rd       = '0;
    ll_data     = '0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    step();
    step();
    idle();
    check_value("rst_ready", ll_ready, 1);
    check_value("rst_stall", pipe_stall, 0);

    // Pipe write and hold-on-idle
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    step();
    check_value("t1_rw", reg_write, 1);
    check_value("t1_wreg", write_reg, 5);
    check_value("t1_wdata", write_data, 32'hDEADBEEF);
    idle();
    step();
    check_value("t1_rw_drop", reg_write, 0);
    check_value("t1_hold", write_data, 32'hDEADBEEF);

    // Issue to writeback
    ll_issue = 1'b1; ll_issue_rd = 5'd7;
    step();
    check_value("t2_busy_set", busy[7], 1);
    idle();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
    step();
    idle();
    check_value("t2_no_early", reg_write, 0);
    step();
    check_value("t2_rw", reg_write, 1);
    check_value("t2_wreg", write_reg, 7);
    check_value("t2_wdata", write_data, 32'h1234);
    check_value("t2_busy_clr", busy[7], 0);
    step();

    // Starvation
    ll_issue = 1'b1; ll_issue_rd = 5'd9;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    step();
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    repeat (LIMIT) step();
    check_value("t3_stall", pipe_stall, 1);
    check_value("t3_pipe_wr", write_reg, 3);
    step();
    check_value("t3_ll_wr", write_reg, 9);
    check_value("t3_busy9", busy[9], 0);
    step();
    check_value("t3_held", write_reg, 3);
    check_value("t3_held_d", write_data, 32'h33);
    idle();
    step();

    // Full FIFO with a saturating pipe
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h44;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA0;
    step();
    ll_rd = 5'd11; ll_data = 32'hB0;
    step();
    check_value("t4_full", ll_ready, 0);
    ll_rd = 5'd12; ll_data = 32'hC0;
    repeat (6) step();
    idle();
    repeat (5) step();

    // x0 handling
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h66;
    ll_issue = 1'b1; ll_issue_rd = 5'd0;
    step();
    idle();
    check_value("t5_rw", reg_write, 0);
    check_value("t5_busy", busy, 0);
    check_value("t5_ready", ll_ready, 1);
    step();
    check_value("t5_no_pop", reg_write, 0);

    // Reset mid-operation
    ll_issue = 1'b1; ll_issue_rd = 5'd4;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h77;
    ll_valid = 1'b1; ll_rd = 5'd13; ll_data = 32'hD0;
    step();
    ll_issue = 1'b0; ll_rd = 5'd14; ll_data = 32'hE0;
    step();
    check_value("t6_busy4", busy[4], 1);
    reset_n = 1'b0;
    step();
    idle();
    check_value("t6_busy", busy, 0);
    check_value("t6_ready", ll_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("t6_no_stale", reg_write, 0);
    end

    // Random traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      pipe_valid  = ($urandom_range(0, 2) != 0);
      pipe_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data   = $urandom;
      ll_issue    = ($urandom_range(0, 3) == 0);
      ll_issue_rd = 5'($urandom_range(0, 31));
      ll_valid    = ($urandom_range(0, 1) != 0);
      ll_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ll_data     = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
